// File: rtl/input_conditioner_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the input conditioner: default parameter values
// and the ceiling-log2 helper used to size the per-channel debounce counter.
package cond_pkg;

  // Two flops is the minimum safe synchroniser depth for a single clock domain.
  localparam int COND_SYNC_STAGES_DEF = 2;

  // Default debounce window in clock cycles.
  localparam int COND_DEBOUNCE_DEF = 16;

  // Ceiling log2, usable in constant expressions.
  // clog2(1)=0, clog2(2)=1, clog2(5)=3, clog2(17)=5.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
`timescale 1ns/1ps
// One conditioned input bit.
//
// Data path:
//   in -> sync_q[0] -> ... -> sync_q[SYNC_STAGES-1] (= in_sync)
//      -> debounce counter -> level_q -> rise_q / fall_q
//
// The synchroniser is a bare shift chain with no logic between stages so
// that only sync_q[0] can go metastable. Everything from in_sync onward is
// ordinary synchronous logic.
//
// Debounce behaviour: in_sync has to differ from level_q on DEBOUNCE_CYCLES
// consecutive edges before level_q takes the new value. Any edge on which
// in_sync agrees with level_q again clears the count, so short glitches never
// reach level_q. The counter saturates by construction: it is cleared when
// it reaches DEBOUNCE_CYCLES-1 and the level flips, so it never wraps.
//
// rise_q/fall_q are loaded on the same edge as level_q. Each one is high for
// exactly the cycle that follows a level change. Both are mutually exclusive
// because a commit changes level_q in only one direction.
module debounce_channel
  import cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = COND_SYNC_STAGES_DEF,
  parameter int   DEBOUNCE_CYCLES = COND_DEBOUNCE_DEF,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic in_sync,
  output logic level,
  output logic rise,
  output logic fall
);

  // Counter spans 0 .. DEBOUNCE_CYCLES-1. It is sized for DEBOUNCE_CYCLES+1
  // values so that DEBOUNCE_CYCLES=1 still gets a 1-bit counter that simply
  // stays at zero.
  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);

  // Count value on which the next disagreeing edge commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic level_q;
  logic level_d;
  logic rise_q;
  logic rise_d;
  logic fall_q;
  logic fall_d;

  // Set when the synchronised input disagrees with the debounced level.
  logic differ;

  // Set when this edge completes the debounce window.
  logic commit;

  // Synchroniser shift chain. Stage 0 samples the raw pin. Reset loads
  // RESET_VALUE so the chain agrees with level_q after reset and no
  // spurious count starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  assign differ = (in_sync != level_q);
  assign commit = differ && (cnt_q == CNT_LAST);

  // Next-state for counter, level and edge pulses.
  // Agreement clears the count. Disagreement either advances the count or,
  // on the final cycle of the window, commits the new level and emits the
  // matching edge pulse.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (commit) begin
      level_d = in_sync;
      rise_d  = in_sync;
      fall_d  = ~in_sync;
    end else if (differ) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers. Reset takes priority over every other update,
  // which aborts any count in progress and suppresses edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
`timescale 1ns/1ps
// Multi-channel input conditioner for asynchronous pins such as buttons,
// switches and off-board strobes.
//
// Each channel is an independent debounce_channel instance, made up of a
// synchroniser chain, a debounce counter and an edge-pulse generator.
// Channels share only clk and rst. Downstream logic may use level, rise and
// fall directly. in_sync is synchronised but not debounced, and is exposed
// for consumers that need low latency and can tolerate bounce.
//
// Latency for a clean step on in[i] captured by stage 0 at edge k:
//   in_sync[i]             at edge k + SYNC_STAGES - 1
//   level[i], rise/fall[i] at edge k + SYNC_STAGES - 1 + DEBOUNCE_CYCLES
//
// Parameter ranges: SYNC_STAGES >= 2, DEBOUNCE_CYCLES >= 1.
module input_conditioner
  import cond_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = COND_SYNC_STAGES_DEF,
  parameter int               DEBOUNCE_CYCLES = COND_DEBOUNCE_DEF,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // One fully independent conditioner per input bit. Each channel takes its
  // own bit of RESET_VALUE as its reset level.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (RESET_VALUE[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .in     (in[i]),
      .in_sync(in_sync[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule
